// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
//
// A WIDTH-bit word is taken over a valid/ready handshake and shifted out one
// bit per edge where tick=1, with first/last framing strobes. A word can
// load on the same edge that consumes the previous word's last bit, which
// gives gap-free back-to-back streams.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-low
//   din        parallel word to transmit
//   din_valid  din holds a word to send
//   din_ready  block can accept a word this cycle (combinational from tick)
//   tick       shift enable; the presented bit is consumed at an edge with tick=1
//   sout       serial data bit (registered)
//   sout_valid sout holds a valid bit (registered)
//   sout_first sout is the first bit of a word (registered)
//   sout_last  sout is the last bit of a word (registered)
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             tick,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  // Bit of the freshly loaded word that goes out first, and the bit of the
  // current shift register that goes out next.
  localparam int FIRST_IDX = MSB_FIRST ? WIDTH - 1 : 0;
  localparam int NEXT_IDX  = MSB_FIRST ? WIDTH - 2 : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             sout_reg, sout_next;
  logic             valid_reg, valid_next;
  logic             first_reg, first_next;
  logic             last_reg, last_next;
  logic             ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      sout_reg  <= 1'b0;
      valid_reg <= 1'b0;
      first_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      sout_reg  <= sout_next;
      valid_reg <= valid_next;
      first_reg <= first_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    sout_next  = sout_reg;
    valid_next = valid_reg;
    first_next = first_reg;
    last_next  = last_reg;
    ready      = 1'b0;

    case (state_reg)
      IDLE: begin
        ready = 1'b1;
      end
      SHIFT: begin
        if (tick) begin
          if (cnt_reg == '0) begin
            // Last bit consumed: either chain the next word or fall idle.
            ready = 1'b1;
            if (!din_valid) begin
              state_next = IDLE;
              shift_next = '0;
              cnt_next   = '0;
              sout_next  = 1'b0;
              valid_next = 1'b0;
              first_next = 1'b0;
              last_next  = 1'b0;
            end
          end else begin
            shift_next = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
            sout_next  = shift_reg[NEXT_IDX];
            cnt_next   = cnt_reg - 1'b1;
            first_next = 1'b0;
            last_next  = (cnt_reg == CW'(1));
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Load path shared by IDLE and the end-of-word edge in SHIFT.
    if (ready && din_valid) begin
      state_next = SHIFT;
      shift_next = din;
      cnt_next   = CNT_MAX;
      sout_next  = din[FIRST_IDX];
      valid_next = 1'b1;
      first_next = 1'b1;
      last_next  = 1'b0;
    end
  end

  assign din_ready  = ready & reset;
  assign sout       = sout_reg;
  assign sout_valid = valid_reg;
  assign sout_first = first_reg;
  assign sout_last  = last_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: drives an MSB-first and an LSB-first instance
// with the same stimulus and checks both against a word/bit-position model.
module tb_piso_serializer;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b0;
  logic         din_valid = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] din = '0;

  logic rdy_m, sout_m, sv_m, sf_m, sl_m;
  logic rdy_l, sout_l, sv_l, sf_l, sl_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .tick(tick), .sout(sout_m), .sout_valid(sv_m),
    .sout_first(sf_m), .sout_last(sl_m));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .tick(tick), .sout(sout_l), .sout_valid(sv_l),
    .sout_first(sf_l), .sout_last(sl_l));

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Tick generator: tick=1 once every 'period' clocks.
  int period = 1;
  int phase = 0;
  always @(posedge clk) begin
    #1;
    tick = (phase == 0);
    phase = (phase + 1 >= period) ? 0 : phase + 1;
  end

  // Model: a word in flight and the position (0..W-1) of the presented bit.
  bit           active = 1'b0;
  int           pos = 0;
  logic [W-1:0] word = '0;
  always @(posedge clk) begin
    if (!reset) begin
      active = 1'b0;
      pos = 0;
    end else if (active && tick) begin
      if (pos < W - 1) pos++;
      else if (din_valid) begin word = din; pos = 0; end
      else active = 1'b0;
    end else if (!active && din_valid) begin
      word = din; pos = 0; active = 1'b1;
    end
  end

  // Bit streams consumed (valid & tick), from the DUTs and from the model.
  logic [15:0] cap_m, cap_l, mcap_m, mcap_l, ncap, mncap;

  always @(negedge clk) begin
    logic exp_m, exp_l, exp_rdy;
    if (checking) begin
      exp_m   = active ? word[W-1-pos] : 1'b0;
      exp_l   = active ? word[pos] : 1'b0;
      exp_rdy = reset && (!active || (pos == W - 1 && tick));
      chk1("ready_m", rdy_m, exp_rdy);
      chk1("ready_l", rdy_l, exp_rdy);
      chk1("sout_m", sout_m, exp_m);
      chk1("sout_l", sout_l, exp_l);
      chk1("valid_m", sv_m, active);
      chk1("valid_l", sv_l, active);
      chk1("first_m", sf_m, active && pos == 0);
      chk1("first_l", sf_l, active && pos == 0);
      chk1("last_m", sl_m, active && pos == W - 1);
      chk1("last_l", sl_l, active && pos == W - 1);
      if (sv_m && tick) begin
        cap_m = {cap_m[14:0], sout_m};
        cap_l = {cap_l[14:0], sout_l};
        ncap  = ncap + 16'd1;
      end
      if (active && tick) begin
        mcap_m = {mcap_m[14:0], exp_m};
        mcap_l = {mcap_l[14:0], exp_l};
        mncap  = mncap + 16'd1;
      end
    end
  end

  task automatic clr();
    cap_m = '0; cap_l = '0; mcap_m = '0; mcap_l = '0; ncap = '0; mncap = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present w until accepted; returns #1 after the accepting edge.
  task automatic send_word(input logic [W-1:0] w, input bit keep_valid);
    bit ok;
    ok = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rdy_m) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout word=%b", w);
    end
    @(posedge clk);
    #1;
    if (!keep_valid) din_valid = 1'b0;
    din = ~w;
    $display("word %b accepted t=%0t", w, $time);
  endtask

  task automatic chk_stream(input string name, input logic [15:0] n,
                            input logic [15:0] exp_m, input logic [15:0] exp_l);
    chk16({name, "_count"}, ncap, n);
    chk16({name, "_bits_m"}, cap_m, exp_m);
    chk16({name, "_bits_l"}, cap_l, exp_l);
    chk16({name, "_model_m"}, mcap_m, exp_m);
    chk16({name, "_model_l"}, mcap_l, exp_l);
    $display("stream %s: n=%0d msb=%b lsb=%b", name, ncap, cap_m[7:0], cap_l[7:0]);
  endtask

  initial begin
    clr();
    // Reset held with din_valid high: nothing may be accepted.
    reset = 1'b0; din_valid = 1'b1; din = 4'hF;
    @(posedge clk); #1;
    checking = 1'b1;
    @(negedge clk);
    chk1("rst_ready", rdy_m, 1'b0);
    chk1("rst_valid", sv_m, 1'b0);
    chk1("rst_sout", sout_m, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; din_valid = 1'b0;
    @(negedge clk);
    chk1("rel_ready", rdy_m, 1'b1);
    idle(1);

    clr(); send_word(4'b1011, 1'b0); idle(6);
    chk_stream("single", 16'd4, 16'b1011, 16'b1101);

    clr(); send_word(4'b1100, 1'b0); idle(6);
    chk_stream("lsbfirst", 16'd4, 16'b1100, 16'b0011);

    clr(); send_word(4'b1001, 1'b1); send_word(4'b0110, 1'b0); idle(8);
    chk_stream("b2b", 16'd8, 16'b10010110, 16'b10010110);

    period = 3;
    clr(); send_word(4'b1010, 1'b0); idle(16);
    chk_stream("paced", 16'd4, 16'b1010, 16'b0101);
    period = 1;
    idle(3);

    // Abort 4'b1111 during its second bit.
    send_word(4'b1111, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk1("abort_valid", sv_m, 1'b0);
    chk1("abort_sout", sout_m, 1'b0);
    idle(1);
    clr(); send_word(4'b0001, 1'b0); idle(6);
    chk_stream("recover", 16'd4, 16'b0001, 16'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
